stall_reg_file: RTL
===================

// Module: stall_reg_file
// PURPOSE
//   Parametrised register file with NUM_RD registered read ports, one write port,
//   a pipeline-stall hold on the read outputs, and optional write-to-read bypass.
//   After reset, a clear sequencer zeroes every entry, so no read ever returns
//   uninitialised state.
//   Feeds stall/hazard logic in the datapath; read outputs are flow-tracked sinks.
// PARAMETERS
//   DW       32  data width of each entry
//   DEPTH    10  number of entries; need not be a power of two
//   NUM_RD    2  number of independent read ports
//   BYPASS    1  1: same-cycle write to the read address is forwarded; 0: old value is read
//   ZERO_REG  0  1: entry 0 always reads 0 and writes to it are dropped
//   AW       derived: $clog2(DEPTH), minimum 1
// PORTS
//   clk      in   1          rising-edge clock
//   rst      in   1          synchronous, active-high reset
//   stall    in   1          1: hold rd_data/rd_valid at their current values
//   wr_en    in   1          write strobe
//   wr_addr  in   AW         write index
//   wr_data  in   DW         write data
//   rd_addr  in   NUM_RD*AW  packed read indices; port i = [i*AW +: AW]
//   rd_data  out  NUM_RD*DW  packed registered read data; port i = [i*DW +: DW]
//   rd_valid out  NUM_RD     per-port: rd_data holds a real read result
//   ready    out  1          1: clear complete; reads and writes are honoured
// BEHAVIOUR
//   Reset (rst sampled high):
//     - rd_data = 0, rd_valid = 0, ready = 0
//     - state <= CLEAR, clr_idx <= 0
//     - reset in any state, including mid-CLEAR, restarts the clear from index 0
//   CLEAR state:
//     - each cycle writes 0 to entry clr_idx, then clr_idx++
//     - after the write of DEPTH-1, state <= RUN
//     - ready rises exactly DEPTH cycles after the first cycle with rst low
//     - wr_en is ignored; stall is ignored
//     - rd_data stays 0 and rd_valid stays 0
//   RUN state: ready = 1 and the state is held until the next reset.
//   Write (RUN only):
//     - commits at the clock edge when wr_en = 1 and wr_addr < DEPTH
//     - commits regardless of stall
//     - dropped when wr_addr >= DEPTH, and dropped for address 0 when ZERO_REG = 1
//   Read, per port i, latency 1:
//     - stall = 0: rd_data_i <= entry[rd_addr_i] sampled this edge, and rd_valid_i <= 1
//     - stall = 1: rd_data_i and rd_valid_i hold their values, no matter how rd_addr
//       or the array changes
//     - rd_addr_i >= DEPTH reads 0
//     - ZERO_REG = 1 and rd_addr_i = 0 reads 0
//     - out-of-range addresses never alias (no modulo wrap)
//   Bypass:
//     - applies when BYPASS = 1 and a committing write matches rd_addr_i in the same
//       non-stalled cycle
//     - rd_data_i <= wr_data
//     - with BYPASS = 0 the pre-write value is returned
//   Multiple ports may read the same address in the same cycle; each sees the same
//   value.
// STRUCTURE
//   Package stall_reg_file_pkg:
//     - rf_state_e enum {RF_CLEAR, RF_RUN}
//     - clog2 helper
//     - RF_ZERO constant
//   Top module: array, clear sequencer (state, clr_idx), write decode.
//   Sub-module rf_read_port (generate NUM_RD times): address range and zero-reg
//   check, bypass mux, stall-hold output register, rd_valid flop.
// TESTING (DW=32, DEPTH=10, NUM_RD=2 unless stated)
//   1. rst high 1 cycle, then low
//      -> ready = 0 for 10 cycles and 1 on the 11th
//      -> all reads of 0..9 return 0
//   2. RUN; wr 0xDEADBEEF to addr 3; next cycle rd_addr0 = 3
//      -> rd_data0 = 0xDEADBEEF one cycle later, rd_valid0 = 1
//   3. wr 0x00001234 to addr 5 with rd_addr1 = 5 in the same cycle
//      -> rd_data1 = 0x1234 next cycle (BYPASS=1)
//      -> rd_data1 = 0 (BYPASS=0)
//   4. rd_data0 = 0xDEADBEEF; stall = 1 for 4 cycles; rd_addr0 -> 5; wr 0xAA to addr 3
//      -> rd_data0 holds 0xDEADBEEF all 4 cycles
//      -> stall = 0: rd_data0 = 0x1234 next cycle
//   5. wr 0x55 to addr 12 (DEPTH=10, AW=4), then read addr 12 and addr 4
//      -> both return 0 (no write, no alias)
//      -> with ZERO_REG = 1: wr 0xFFFF to addr 0, read addr 0 -> 0
//   6. rst asserted when clr_idx = 4
//      -> ready stays 0, the clear restarts at 0
//      -> ready rises 10 cycles after rst falls; a prior write to addr 3 then reads 0

Source files
------------

// File: rtl/stall_reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stall_reg_file_pkg
// Purpose  : Shared types, constants and helpers for stall_reg_file.
//            Contents: rf_state_e, the clear-sequencer state encoding;
//            RF_ZERO, the value written by the clear and returned for
//            masked reads; rf_clog2, an address-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package stall_reg_file_pkg;

    // Clear sequencer states: CLEAR zeroes the array after reset, RUN serves
    // normal traffic until the next reset.
    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    // Value written during the clear and returned for masked reads.
    localparam int RF_ZERO = 0;

    // Ceiling log2, never less than 1, so that a one-entry file still has
    // a one-bit address.
    function automatic int rf_clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stall_reg_file_rd_port.sv
`default_nettype none
// ============================================================================
// Module   : rf_read_port
// Purpose  : One registered read port of stall_reg_file. It selects an entry
//            from the flattened array, masks out-of-range and zero-register
//            reads, forwards a same-cycle write when bypass is enabled, and
//            holds its output register while stalled.
// Ports    : clk, rst          clock and synchronous active-high reset
//            i_run             array is cleared; reads may update
//            i_stall           hold o_rd_data / o_rd_valid
//            i_rd_addr         read index
//            i_mem_flat        all entries, entry k at [k*DW +: DW]
//            i_wr_commit       a write commits at this edge
//            i_wr_addr/data    index and data of that write
//            o_rd_data         registered read data
//            o_rd_valid        o_rd_data holds a real read result
// Revision : 1.0 - initial release
// ============================================================================
module rf_read_port
    import stall_reg_file_pkg::*;
#(
    parameter int DW       = 32,
    parameter int DEPTH    = 10,
    parameter int AW       = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_run,
    input  logic                i_stall,
    input  logic [AW-1:0]       i_rd_addr,
    input  logic [DEPTH*DW-1:0] i_mem_flat,
    input  logic                i_wr_commit,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [DW-1:0]       i_wr_data,
    output logic [DW-1:0]       o_rd_data,
    output logic                o_rd_valid
);

    logic          w_zero_hit;
    logic          w_bypass_hit;
    logic [DW-1:0] w_arr_data;
    logic [DW-1:0] w_rd_next;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;

    assign w_zero_hit   = (ZERO_REG != 0) && (i_rd_addr == '0);
    // The write port already refuses out-of-range and zero-register writes,
    // so a committing write is always safe to forward.
    assign w_bypass_hit = (BYPASS != 0) && i_wr_commit && (i_wr_addr == i_rd_addr);

    // Compare against every legal index rather than slicing by the address:
    // an address at or above DEPTH matches nothing and reads zero, with no
    // modulo aliasing onto a real entry.
    always_comb begin
        w_arr_data = DW'(RF_ZERO);
        for (int k = 0; k < DEPTH; k++) begin
            if (i_rd_addr == AW'(k)) begin
                w_arr_data = i_mem_flat[k*DW +: DW];
            end
        end
        if (w_zero_hit) begin
            w_arr_data = DW'(RF_ZERO);
        end
    end

    assign w_rd_next = w_bypass_hit ? i_wr_data : w_arr_data;

    // Outputs stay zero and invalid until the clear has finished; after that
    // a stall freezes them regardless of address or array activity.
    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_rd_data  <= DW'(RF_ZERO);
            r_rd_valid <= 1'b0;
        end else if (!i_stall) begin
            r_rd_data  <= w_rd_next;
            r_rd_valid <= 1'b1;
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: rtl/stall_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : stall_reg_file
// Purpose  : Parametrised register file with NUM_RD registered read ports,
//            one write port, stall hold on the read outputs and optional
//            write-to-read bypass. After reset a sequencer zeroes every entry
//            before any access is honoured.
// Ports    : clk, rst     clock and synchronous active-high reset
//            stall        hold rd_data / rd_valid
//            wr_en        write strobe
//            wr_addr      write index
//            wr_data      write data
//            rd_addr      packed read indices, port i at [i*AW +: AW]
//            rd_data      packed read data, port i at [i*DW +: DW]
//            rd_valid     per-port: rd_data holds a real read result
//            ready        clear complete; reads and writes are honoured
// Revision : 1.0 - initial release
// ============================================================================
module stall_reg_file
    import stall_reg_file_pkg::*;
#(
    parameter int DW       = 32,
    parameter int DEPTH    = 10,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    parameter int AW       = rf_clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_valid,
    output logic                 ready
);

    // One extra bit so the bound still fits when DEPTH is a power of two.
    localparam logic [AW:0]   c_depth    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);

    rf_state_e           r_state;
    rf_state_e           w_state_nxt;
    logic [AW-1:0]       r_clr_idx;
    logic [AW-1:0]       w_clr_idx_nxt;
    logic                w_clr_we;
    logic                w_run;
    logic                w_addr_ok;
    logic                w_zero_drop;
    logic                w_wr_commit;
    logic [DW-1:0]       r_mem [DEPTH];
    logic [DEPTH*DW-1:0] w_mem_flat;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RF_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_clr_we      = 1'b0;
        case (r_state)
            RF_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_idx == c_last_idx) begin
                    w_state_nxt   = RF_RUN;
                    w_clr_idx_nxt = '0;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + AW'(1);
                end
            end
            RF_RUN: begin
                w_state_nxt = RF_RUN;
            end
            default: begin
                w_state_nxt   = RF_CLEAR;
                w_clr_idx_nxt = '0;
            end
        endcase
    end

    assign w_run = (r_state == RF_RUN);
    assign ready = w_run;

    // ------------------------------------------------------------------
    // Write decode and array
    // ------------------------------------------------------------------
    assign w_addr_ok   = ({1'b0, wr_addr} < c_depth);
    assign w_zero_drop = (ZERO_REG != 0) && (wr_addr == '0);
    // Reset outranks a write arriving in the same cycle, so a clear that
    // restarts never sees a late write slip into the array.
    assign w_wr_commit = w_run && wr_en && w_addr_ok && !w_zero_drop && !rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_we) begin
                r_mem[r_clr_idx] <= DW'(RF_ZERO);
            end else if (w_wr_commit) begin
                r_mem[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign w_mem_flat[g*DW +: DW] = r_mem[g];
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
        rf_read_port #(
            .DW       (DW),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk         (clk),
            .rst         (rst),
            .i_run       (w_run),
            .i_stall     (stall),
            .i_rd_addr   (rd_addr[p*AW +: AW]),
            .i_mem_flat  (w_mem_flat),
            .i_wr_commit (w_wr_commit),
            .i_wr_addr   (wr_addr),
            .i_wr_data   (wr_data),
            .o_rd_data   (rd_data[p*DW +: DW]),
            .o_rd_valid  (rd_valid[p])
        );
    end

endmodule
`default_nettype wire
